// File: rtl/divider.sv
// 18-bit restoring divider peripheral: dividend/divisor writes, quotient/remainder reads.
// Results are valid 18 edges after the divisor write (DONE rises); a new divisor write restarts at once.
module divider (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CS,
  input  logic        WE,
  input  logic        SN,
  input  logic        AD,
  input  logic [17:0] DI,
  output logic [17:0] DO,
  output logic        DONE
);

  logic [17:0] dividend;
  logic [17:0] dvd_orig;
  logic [17:0] a_sh;
  logic [17:0] b_mag;
  logic [17:0] pr;
  logic [17:0] q_sh;
  logic [17:0] quo;
  logic [17:0] rem;
  logic        neg_q;
  logic        neg_r;
  logic        done;
  logic [4:0]  cnt;

  logic        wr_dvd;
  logic        wr_dvs;
  logic [17:0] dvd_mag;
  logic [17:0] dvs_mag;
  logic [18:0] pr_sh;
  logic        ge;
  logic [17:0] diff;
  logic [17:0] pr_nx;
  logic [17:0] q_nx;
  logic [17:0] quo_fin;
  logic [17:0] rem_fin;

  assign wr_dvd = CS & WE & ~AD;
  assign wr_dvs = CS & WE & AD;

  // Magnitudes for signed mode; -131072 negates to itself, which reads as 0x20000 unsigned.
  assign dvd_mag = (SN & dividend[17]) ? -dividend : dividend;
  assign dvs_mag = (SN & DI[17])       ? -DI       : DI;

  // Only the low 18 bits of the difference matter: it is used only when pr_sh >= b_mag.
  always_comb begin
    pr_sh   = {pr, a_sh[17]};
    ge      = (pr_sh >= {1'b0, b_mag});
    diff    = pr_sh[17:0] - b_mag;
    pr_nx   = ge ? diff : pr_sh[17:0];
    q_nx    = {q_sh[16:0], ge};
    quo_fin = neg_q ? -q_nx : q_nx;
    rem_fin = neg_r ? -pr_nx : pr_nx;
    if (b_mag == 18'd0) begin
      quo_fin = 18'h3FFFF;
      rem_fin = dvd_orig;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dividend <= '0;
      dvd_orig <= '0;
      a_sh     <= '0;
      b_mag    <= '0;
      pr       <= '0;
      q_sh     <= '0;
      quo      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= '0;
      done     <= 1'b1;
    end else begin
      if (wr_dvd) dividend <= DI;
      // A divisor write wins over an in-flight iteration, including the completion edge.
      if (wr_dvs) begin
        a_sh     <= dvd_mag;
        b_mag    <= dvs_mag;
        dvd_orig <= dividend;
        neg_q    <= SN & (dividend[17] ^ DI[17]);
        neg_r    <= SN & dividend[17];
        pr       <= '0;
        q_sh     <= '0;
        cnt      <= 5'd18;
        done     <= 1'b0;
      end else if (!done) begin
        a_sh <= a_sh << 1;
        pr   <= pr_nx;
        q_sh <= q_nx;
        cnt  <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          quo  <= quo_fin;
          rem  <= rem_fin;
          done <= 1'b1;
        end
      end
    end
  end

  assign DO   = AD ? rem : quo;
  assign DONE = done;

endmodule

// File: tb/tb_divider.sv
// Directed and random checks of the divider against an integer-arithmetic reference.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs, we, sn, ad;
  logic [17:0] di;
  logic [17:0] dout;
  logic        done;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  divider dut (
    .CLK(clk), .RST_N(rst_n), .CS(cs), .WE(we), .SN(sn), .AD(ad),
    .DI(di), .DO(dout), .DONE(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic a, input logic [17:0] d, input logic s);
    cs = 1'b1; we = 1'b1; ad = a; di = d; sn = s;
    tick();
    cs = 1'b0; we = 1'b0; ad = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [17:0] q_exp, input logic [17:0] r_exp);
    ad = 1'b0;
    #1 check({tag, " quo"}, dout, q_exp);
    ad = 1'b1;
    #1 check({tag, " rem"}, dout, r_exp);
    ad = 1'b0;
  endtask

  // Truncating division on plain integers; divide-by-zero returns all ones and the dividend.
  task automatic ref_div(input logic [17:0] dvd, input logic [17:0] dvs, input logic s,
                         output logic [17:0] q, output logic [17:0] r);
    int a, b, qi, ri;
    if (dvs == 18'd0) begin
      q = 18'h3FFFF;
      r = dvd;
    end else begin
      a = int'(dvd);
      b = int'(dvs);
      if (s && dvd[17]) a = a - 262144;
      if (s && dvs[17]) b = b - 262144;
      qi = a / b;
      ri = a % b;
      q  = qi[17:0];
      r  = ri[17:0];
    end
  endtask

  task automatic run_op(input string tag, input logic [17:0] dvd, input logic [17:0] dvs,
                        input logic s, input logic [17:0] q_exp, input logic [17:0] r_exp,
                        input bit busy_chk);
    wr(1'b0, dvd, s);
    wr(1'b1, dvs, s);
    if (busy_chk) begin
      check({tag, " done edge0"}, 18'(done), 18'd0);
      for (int i = 1; i <= 17; i++) begin
        tick();
        check($sformatf("%s done cyc%0d", tag, i), 18'(done), 18'd0);
      end
    end else begin
      repeat (17) tick();
    end
    tick();
    check({tag, " done"}, 18'(done), 18'd1);
    read_check(tag, q_exp, r_exp);
  endtask

  initial begin
    logic [17:0] rd, rv, eq, er;
    logic        rs;
    int          mode;

    rst_n = 1'b0; cs = 1'b0; we = 1'b0; sn = 1'b0; ad = 1'b0; di = '0;
    #12;
    check("reset done", 18'(done), 18'd1);
    read_check("reset", 18'd0, 18'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("s 23/5",    18'd23,        18'd5,         1'b1, 18'o000004, 18'o000003, 1'b1);
    run_op("s 23/-5",   18'd23,        18'o777773,    1'b1, 18'o777774, 18'o000003, 1'b0);
    run_op("s -23/5",   18'o777751,    18'd5,         1'b1, 18'o777774, 18'o777775, 1'b0);
    run_op("s -23/-5",  18'o777751,    18'o777773,    1'b1, 18'o000004, 18'o777775, 1'b0);
    run_op("u big/500", 18'd200050,    18'd500,       1'b0, 18'd400,    18'd50,     1'b0);
    run_op("u 500/big", 18'd500,       18'd200050,    1'b0, 18'd0,      18'd500,    1'b0);
    run_op("u 7/0",     18'd7,         18'd0,         1'b0, 18'h3FFFF,  18'd7,      1'b0);
    run_op("s -7/0",    18'h3FFF9,     18'd0,         1'b1, 18'h3FFFF,  18'h3FFF9,  1'b0);
    run_op("s ovf",     18'h20000,     18'h3FFFF,     1'b1, 18'h20000,  18'd0,      1'b0);

    // Previous results hold while busy; a mid-operation dividend write only affects the next op.
    wr(1'b0, 18'd100, 1'b0);
    wr(1'b1, 18'd7, 1'b0);
    repeat (3) tick();
    read_check("hold", 18'h20000, 18'd0);
    wr(1'b0, 18'd999, 1'b0);
    repeat (13) tick();
    check("hold done cyc17", 18'(done), 18'd0);
    tick();
    check("hold done", 18'(done), 18'd1);
    read_check("hold 100/7", 18'd14, 18'd2);
    wr(1'b1, 18'd10, 1'b0);
    repeat (18) tick();
    read_check("next 999/10", 18'd99, 18'd9);

    // Restart mid-operation: timing counts from the second divisor write.
    wr(1'b0, 18'd1000, 1'b0);
    wr(1'b1, 18'd3, 1'b0);
    repeat (6) tick();
    wr(1'b1, 18'd7, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      tick();
      check($sformatf("restart done cyc%0d", i), 18'(done), 18'd0);
    end
    tick();
    check("restart done", 18'(done), 18'd1);
    read_check("restart 1000/7", 18'd142, 18'd6);

    // Divisor write on the completion edge keeps DONE low.
    wr(1'b0, 18'd50, 1'b0);
    wr(1'b1, 18'd5, 1'b0);
    repeat (17) tick();
    wr(1'b1, 18'd6, 1'b0);
    check("prio done", 18'(done), 18'd0);
    repeat (17) tick();
    tick();
    check("prio done end", 18'(done), 18'd1);
    read_check("prio 50/6", 18'd8, 18'd2);

    // Asynchronous reset mid-division.
    wr(1'b0, 18'd123, 1'b0);
    wr(1'b1, 18'd4, 1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1 check("arst done", 18'(done), 18'd1);
    read_check("arst", 18'd0, 18'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wr(1'b1, 18'd5, 1'b0);
    repeat (18) tick();
    read_check("post-rst 0/5", 18'd0, 18'd0);

    for (int n = 0; n < 24; n++) begin
      rd   = 18'($urandom);
      mode = int'($urandom_range(0, 7));
      case (mode)
        0:       rv = 18'd0;
        1:       rv = 18'($urandom_range(1, 15));
        2:       rv = 18'h3FFFF;
        default: rv = 18'($urandom);
      endcase
      if (n == 0) rd = 18'h20000;
      rs = 1'($urandom_range(0, 1));
      ref_div(rd, rv, rs, eq, er);
      run_op($sformatf("rnd%0d %h/%h s%0d", n, rd, rv, rs), rd, rv, rs, eq, er, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
